// File: rtl/seg7_scan_reader_if.sv
// Display-bus bundle for seg7_scan_reader: observed segment/anode lines,
// clear strobe and recovered-digit outputs.
// SEG7_READER_DP_EN adds the decimal-point input and per-digit dp outputs.
interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   valid_out;
  logic                    update;
  logic                    err_sticky;
`ifdef SEG7_READER_DP_EN
  logic                    dp_in;
  logic [NUM_DIGITS-1:0]   dp_out;
`endif

  modport master (
    output seg_in, an_in, clr,
`ifdef SEG7_READER_DP_EN
    output dp_in,
    input  dp_out,
`endif
    input  digits_out, valid_out, update, err_sticky
  );

  modport slave (
    input  seg_in, an_in, clr,
`ifdef SEG7_READER_DP_EN
    input  dp_in,
    output dp_out,
`endif
    output digits_out, valid_out, update, err_sticky
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Recovers the hex digits shown on a multiplexed common-anode 7-segment bus.
// Each synchronised sample must repeat STABLE_CYCLES times before it is
// reverse-decoded into the nibble selected by the single low anode line.
// Optional decimal-point tracking is enabled with SEG7_READER_DP_EN.
//
// state | meaning
// IDLE  | anode sample illegal (not exactly one low) or just cleared
// COUNT | counting consecutive identical samples against the reference
// HELD  | reference captured; waiting for the bus to change
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_reader_if.slave bus
);
`ifdef SEG7_READER_DP_EN
  localparam int DPW = 1;
`else
  localparam int DPW = 0;
`endif
  localparam int SW = 7 + NUM_DIGITS + DPW;

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  logic [SW-1:0]           pins, sync1, sync2, ref_q, ref_n;
  logic [6:0]              s_seg;
  logic [NUM_DIGITS-1:0]   s_an;
  state_t                  state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic                    legal, capture;
  logic [3:0]              slot;
  logic                    dec_ok, blank;
  logic [3:0]              dec_val;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_n;
  logic [NUM_DIGITS-1:0]   valid_q, valid_n;
  logic                    err_q, err_n, update_q;
`ifdef SEG7_READER_DP_EN
  logic                    s_dp;
  logic [NUM_DIGITS-1:0]   dp_q, dp_n;

  assign pins = {bus.dp_in, bus.an_in, bus.seg_in};
  assign s_dp = sync2[SW-1];
  assign bus.dp_out = dp_q;
`else
  assign pins = {bus.an_in, bus.seg_in};
`endif
  assign s_seg = sync2[6:0];
  assign s_an  = sync2[7 +: NUM_DIGITS];

  // Two-flop synchroniser; resets to the idle (all-high) bus value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

  // Legality check and slot index of the single active anode
  always_comb begin
    legal = ($countones(~s_an) == 1);
    slot  = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!s_an[i]) slot = 4'(i);
  end

  // Reverse segment map; blank is recognised separately so it never flags an error
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    blank   = (s_seg == 7'h7F);
    case (s_seg)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // FSM state, stability counter and reference sample registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      ref_q <= '1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ref_q <= ref_n;
    end
  end

  // Next-state logic; capture fires on the sample that completes the window
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ref_n   = ref_q;
    capture = 1'b0;
    if (bus.clr || !legal) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = COUNT;
          cnt_n   = 8'd1;
          ref_n   = sync2;
        end
        COUNT: begin
          if (sync2 == ref_q) begin
            if (cnt == 8'(STABLE_CYCLES - 1)) begin
              capture = 1'b1;
              state_n = HELD;
              cnt_n   = 8'(STABLE_CYCLES);
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end else begin
            ref_n = sync2;
            cnt_n = 8'd1;
          end
        end
        HELD: begin
          if (sync2 != ref_q) begin
            state_n = COUNT;
            ref_n   = sync2;
            cnt_n   = 8'd1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end
      endcase
    end
  end

  // Candidate output values for a capture at the current slot
  always_comb begin
    digits_n = digits_q;
    valid_n  = valid_q;
    err_n    = err_q;
`ifdef SEG7_READER_DP_EN
    dp_n     = dp_q;
`endif
    valid_n[slot] = 1'b0;
    if (dec_ok) begin
      digits_n[4*slot +: 4] = dec_val;
      valid_n[slot]         = 1'b1;
    end else if (!blank) begin
      err_n = 1'b1;
    end
`ifdef SEG7_READER_DP_EN
    if (dec_ok || blank) dp_n[slot] = ~s_dp;
`endif
  end

  // Output registers; clr wins over a coincident capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
`ifdef SEG7_READER_DP_EN
      dp_q     <= '0;
`endif
    end else if (bus.clr) begin
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
`ifdef SEG7_READER_DP_EN
      dp_q     <= '0;
`endif
    end else if (capture) begin
      digits_q <= digits_n;
      valid_q  <= valid_n;
      err_q    <= err_n;
      update_q <= (digits_n != digits_q) || (valid_n != valid_q);
`ifdef SEG7_READER_DP_EN
      dp_q     <= dp_n;
`endif
    end else begin
      update_q <= 1'b0;
    end
  end

  assign bus.digits_out = digits_q;
  assign bus.valid_out  = valid_q;
  assign bus.err_sticky = err_q;
  assign bus.update     = update_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: expected captures are queued
// when stimulus is applied and compared whenever the DUT pulses update.
module tb_seg7_scan_reader;
  localparam int ND = 4;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   upd_count = 0;
  int   upd_cyc  = -1;
  int   t0, u0;

  logic [3:0] an_tab [4];
  logic [6:0] seg_tab[4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    bus.an_in  = an;
    bus.seg_in = seg;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // cycle counter used to time update pulses
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every update pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.update === 1'b1) begin
      upd_count++;
      upd_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("unexpected_update", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("upd_digits", 32'(bus.digits_out), 32'(mon_e.dig));
        check_val("upd_valid", 32'(bus.valid_out), 32'(mon_e.val));
      end
    end
  end

  initial begin
    an_tab[0] = 4'b1110; seg_tab[0] = 7'h79;
    an_tab[1] = 4'b1101; seg_tab[1] = 7'h24;
    an_tab[2] = 4'b1011; seg_tab[2] = 7'h30;
    an_tab[3] = 4'b0111; seg_tab[3] = 7'h19;

    rst_n   = 1'b0;
    bus.clr = 1'b0;
    drive(4'b1111, 7'h7F);
`ifdef SEG7_READER_DP_EN
    bus.dp_in = 1'b1;
`endif
    tick(3);
    check_val("rst_digits", 32'(bus.digits_out), 32'h0);
    check_val("rst_valid", 32'(bus.valid_out), 32'h0);
    check_val("rst_err", 32'(bus.err_sticky), 32'h0);
    check_val("rst_update", 32'(bus.update), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // single digit 0 on slot 0; update expected 6 cycles after drive
    exp_q.push_back('{dig: 16'h0000, val: 4'b0001});
    drive(4'b1110, 7'h40);
    t0 = cyc;
    tick(10);
    check_val("t1_latency", 32'(upd_cyc - t0), 32'd6);
    check_val("t1_valid", 32'(bus.valid_out), 32'b0001);
    check_val("t1_updates", 32'(upd_count), 32'd1);

    // scan 1,2,3,4 twice; second pass is an identical recapture
    u0 = upd_count;
    exp_q.push_back('{dig: 16'h0001, val: 4'b0001});
    exp_q.push_back('{dig: 16'h0021, val: 4'b0011});
    exp_q.push_back('{dig: 16'h0321, val: 4'b0111});
    exp_q.push_back('{dig: 16'h4321, val: 4'b1111});
    for (int lp = 0; lp < 2; lp++)
      for (int d = 0; d < 4; d++) begin
        drive(an_tab[d], seg_tab[d]);
        tick(8);
      end
    check_val("t2_digits", 32'(bus.digits_out), 32'h4321);
    check_val("t2_valid", 32'(bus.valid_out), 32'b1111);
    check_val("t2_updates", 32'(upd_count - u0), 32'd4);

    // patterns held only 3 cycles never capture
    u0 = upd_count;
    for (int r = 0; r < 4; r++) begin
      drive(4'b1110, 7'h24); tick(3);
      drive(4'b1101, 7'h30); tick(3);
    end
    check_val("t3_digits", 32'(bus.digits_out), 32'h4321);
    check_val("t3_valid", 32'(bus.valid_out), 32'b1111);
    check_val("t3_updates", 32'(upd_count - u0), 32'd0);

    // illegal anodes, then blank, then unrecognised pattern on slot 2
    u0 = upd_count;
    drive(4'b1100, 7'h00);
    tick(20);
    check_val("t4_illegal_upd", 32'(upd_count - u0), 32'd0);
    check_val("t4_illegal_dig", 32'(bus.digits_out), 32'h4321);
    exp_q.push_back('{dig: 16'h4321, val: 4'b1011});
    drive(4'b1011, 7'h7F);
    tick(10);
    check_val("t4_blank_valid", 32'(bus.valid_out), 32'b1011);
    check_val("t4_blank_err", 32'(bus.err_sticky), 32'd0);
    drive(4'b1011, 7'h7E);
    tick(10);
    check_val("t4_bad_err", 32'(bus.err_sticky), 32'd1);
    check_val("t4_bad_valid", 32'(bus.valid_out), 32'b1011);
    check_val("t4_updates", 32'(upd_count - u0), 32'd1);

    // clr on the capture cycle of F, recapture 4 cycles later
    drive(4'b1110, 7'h0E);
    t0 = cyc;
    tick(5);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    check_val("t5_clr_digits", 32'(bus.digits_out), 32'h0);
    check_val("t5_clr_valid", 32'(bus.valid_out), 32'h0);
    check_val("t5_clr_err", 32'(bus.err_sticky), 32'd0);
    check_val("t5_clr_update", 32'(bus.update), 32'd0);
    exp_q.push_back('{dig: 16'h000F, val: 4'b0001});
    tick(6);
    check_val("t5_recap_cycle", 32'(upd_cyc - t0), 32'd10);
    check_val("t5_recap_digits", 32'(bus.digits_out), 32'h000F);

    // reset mid-window (counter at 2)
    drive(4'b1101, 7'h24);
    tick(4);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_digits", 32'(bus.digits_out), 32'h0);
    check_val("t6_rst_valid", 32'(bus.valid_out), 32'h0);
    check_val("t6_rst_update", 32'(bus.update), 32'd0);
    exp_q.push_back('{dig: 16'h0020, val: 4'b0010});
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check_val("t6_after_digits", 32'(bus.digits_out), 32'h0020);
    check_val("t6_after_valid", 32'(bus.valid_out), 32'b0010);

`ifdef SEG7_READER_DP_EN
    // decimal point lit with digit A on slot 3
    exp_q.push_back('{dig: 16'hA020, val: 4'b1010});
    bus.dp_in = 1'b0;
    drive(4'b0111, 7'h08);
    tick(10);
    check_val("dp_digits", 32'(bus.digits_out), 32'hA020);
    check_val("dp_out", 32'(bus.dp_out), 32'b1000);
`endif

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Observes a multiplexed common-anode 7-segment display bus (active-low segments, active-low digit anodes) and recovers the hex digit shown on each digit position.
- Receive-side counterpart of the BCD-to-segment decoder; used as an on-chip display loopback checker and as a readback monitor for the display driver.
- Filters scan transitions and ghosting with a per-sample stability window, then reverse-maps each segment pattern to a 4-bit value.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (anode lines), 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture, 2..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines, active-low; bit0=a, bit1=b, ..., bit6=g.
- an_in  input  NUM_DIGITS  anode enables, active-low; bit i selects digit i.
- clr  input  1  synchronous clear of captured digits and error flag.
- digits_out  output  4*NUM_DIGITS  recovered digits; nibble i = digit i.
- valid_out  output  NUM_DIGITS  bit i set when nibble i holds a decoded value.
- update  output  1  one-cycle pulse when any nibble or valid bit changes.
- err_sticky  output  1  set on a stable, non-blank, unrecognised pattern; cleared only by clr/reset.

Behaviour:
- Reset (async, rst_n=0): digits_out=0, valid_out=0, update=0, err_sticky=0, synchronisers=all-ones (idle bus), counter=0, FSM=IDLE.
- Input stage: seg_in and an_in pass through a two-flop synchroniser; all logic below uses the synchronised sample S.
- Legal sample: exactly one bit of S.an is 0. Any other anode value is illegal.
- FSM states and transitions:
  - IDLE: entered on an illegal sample from any state. On a legal sample, load counter=1, store S as the reference, go to COUNT.
  - COUNT: if S equals the reference (segments and anodes), increment counter. When counter reaches STABLE_CYCLES, capture and go to HELD. If S differs and is legal, reload the reference, set counter=1, stay in COUNT.
  - HELD: no recapture while S equals the reference. If S differs and is legal, go to COUNT with counter=1.
- Capture, at slot k = index of the low anode bit. Recognised codes (seg[6:0], hex) for digits 0..F:
  40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Capture results:
  - Match: nibble k=value, valid_out[k]=1.
  - Pattern 7F (blank): valid_out[k]=0, nibble k unchanged, no error.
  - Any other pattern: valid_out[k]=0, err_sticky=1.
- Output timing: registered, updated the cycle after the counter reaches STABLE_CYCLES. Latency from a stable change at the pins to the output is 2 + STABLE_CYCLES cycles.
- update: pulses for one cycle after a capture only if digits_out or valid_out changed. It does not pulse for an identical recapture.
- clr: zeroes digits_out, valid_out, err_sticky and forces the FSM to IDLE. update stays 0 that cycle. If clr coincides with a capture, clr wins and the capture is discarded.
- Counter saturates; it never wraps inside HELD.
- Reset asserted mid-window discards the partial window. Operation restarts from IDLE after reset release.

Optional Feature:
- Macro SEG7_READER_DP_EN.
- Defined:
  - Adds port dp_in (input, 1, decimal point, active-low) and port dp_out (output, NUM_DIGITS).
  - dp_in is synchronised with seg_in and included in the stability comparison.
  - On a match or blank capture, dp_out[k] = ~dp; on an unrecognised pattern, dp_out[k] is unchanged.
  - Reset and clr set dp_out=0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset, then drive an_in=1110, seg_in=40 (digit 0) for 10 cycles -> nibble0=0, valid_out=0001, one update pulse at cycle 2+4=6 after the drive.
- Scan digits 1,2,3,4 (an=1110,1101,1011,0111; seg=79,24,30,19), 8 cycles each, looped twice -> digits_out=16'h4321, valid_out=1111, exactly 4 update pulses (none on the second loop).
- Hold a legal pattern only 3 cycles between anode changes (less than STABLE_CYCLES) -> no capture, outputs unchanged, no update.
- Drive an_in=1100 (two anodes low) with seg=00 for 20 cycles -> FSM stays IDLE, no capture. Then an=1011, seg=7F -> valid_out[2]=0, err_sticky=0. Then seg=7E -> err_sticky=1, valid_out[2]=0.
- Assert clr on the exact cycle a capture of seg=0E (F) completes -> digits_out=0, valid_out=0, err_sticky=0, no update. Recapture occurs 4 cycles after clr deasserts.
- Assert rst_n=0 mid-window (counter=2), release -> all outputs 0. With SEG7_READER_DP_EN defined, seg=08 with dp_in=0 -> nibble=A, dp_out[k]=1.
